// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction issuer and its program memory.
// The optional drain watchdog in mips_issuer is enabled with MIPS_ISSUER_WDT_EN.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef logic [31:0] word_t;
    typedef logic [19:0] oreg_t;

    localparam int INSTR_W = 32;
    localparam int OREG_W  = 20;
    localparam int ENTRY_W = INSTR_W + OREG_W;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    function automatic logic [5:0] opcode_of(input word_t instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/mips_issuer_mem.sv
// Program memory for mips_issuer: DEPTH entries of {instruction, output_reg},
// one synchronous write port and one combinational read port.
module mips_issuer_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ENTRY_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ENTRY_W-1:0]       rdata
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mips_issuer.sv
// Streams a preloaded instruction program to a core and gathers its results.
// Define MIPS_ISSUER_WDT_EN to add a drain watchdog that raises timeout.
module mips_issuer
    import mips_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int WDT_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_instr,
    input  logic [19:0]              prog_oreg,
    input  logic [$clog2(DEPTH):0]   prog_len,
    input  logic                     start,
    output logic                     in_valid,
    output logic [31:0]              instruction,
    output logic [19:0]              output_reg,
    input  logic                     out_valid,
    input  logic                     instruction_fail,
    input  logic [31:0]              out_1,
    input  logic [31:0]              out_2,
    input  logic [31:0]              out_3,
    input  logic [31:0]              out_4,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   fail_cnt,
    output logic [31:0]              res_sum
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 32 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mips_issuer: DEPTH must be a power of two between 2 and 32");
    end
    if (WDT_CYCLES < 1) begin : g_bad_wdt
        $error("mips_issuer: WDT_CYCLES must be at least 1");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] len_q,   len_d;
    logic [CW-1:0] idx_q,   idx_d;
    logic [CW-1:0] rcv_q,   rcv_d;
    logic [CW-1:0] fail_q,  fail_d;
    word_t         sum_q,   sum_d;
    logic          done_q,  done_d;
    logic [ENTRY_W-1:0] rd_entry;

`ifdef MIPS_ISSUER_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);
    logic [WW-1:0] wdt_q, wdt_d;
    logic          tmo_q, tmo_d;
`endif

    function automatic word_t sum4(input word_t a, input word_t b,
                                   input word_t c, input word_t d);
        return a + b + c + d;
    endfunction

    function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] l);
        return (l > CW'(DEPTH)) ? CW'(DEPTH) : l;
    endfunction

    mips_issuer_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we && (state_q == ST_IDLE)),
        .waddr (prog_addr),
        .wdata ({prog_instr, prog_oreg}),
        .raddr (idx_q[AW-1:0]),
        .rdata (rd_entry)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rcv_d   = rcv_q;
        fail_d  = fail_q;
        sum_d   = sum_q;
        done_d  = 1'b0;
`ifdef MIPS_ISSUER_WDT_EN
        wdt_d   = wdt_q;
        tmo_d   = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start && (prog_len != '0)) begin
                    state_d = ST_ISSUE;
                    len_d   = clamp_len(prog_len);
                    idx_d   = '0;
                    rcv_d   = '0;
                    fail_d  = '0;
                    sum_d   = '0;
`ifdef MIPS_ISSUER_WDT_EN
                    wdt_d   = '0;
`endif
                end
            end
            ST_ISSUE: begin
                idx_d = idx_q + CW'(1);
                if (idx_q == len_q - CW'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
`ifdef MIPS_ISSUER_WDT_EN
                // The pulse cycle itself is the last of the WDT_CYCLES quiet cycles.
                if (out_valid) begin
                    wdt_d = '0;
                end else if (int'(wdt_q) + 1 >= WDT_CYCLES - 1) begin
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    wdt_d = wdt_q + WW'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Results are accepted in ISSUE as well as DRAIN; issue never stalls for them.
        if ((state_q != ST_IDLE) && out_valid) begin
            rcv_d = rcv_q + CW'(1);
            if (instruction_fail) begin
                fail_d = fail_q + CW'(1);
            end else begin
                sum_d = sum_q + sum4(out_1, out_2, out_3, out_4);
            end
            if (rcv_q + CW'(1) == len_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            rcv_q   <= '0;
            fail_q  <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rcv_q   <= rcv_d;
            fail_q  <= fail_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

`ifdef MIPS_ISSUER_WDT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            wdt_q <= wdt_d;
            tmo_q <= tmo_d;
        end
    end
    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    assign busy        = (state_q != ST_IDLE);
    assign in_valid    = (state_q == ST_ISSUE);
    assign instruction = in_valid ? rd_entry[ENTRY_W-1:OREG_W] : '0;
    assign output_reg  = in_valid ? rd_entry[OREG_W-1:0] : '0;
    assign done        = done_q;
    assign fail_cnt    = fail_q;
    assign res_sum     = sum_q;

endmodule

// File: tb/tb_mips_issuer.sv
// Self-checking bench for mips_issuer: randomized runs against a run-level reference model,
// plus directed scenarios with hand-computed results. Honours MIPS_ISSUER_WDT_EN.
module tb_mips_issuer;
    import mips_pkg::*;

    localparam int DEPTH = 16;
    localparam int WDT   = 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
`ifdef MIPS_ISSUER_WDT_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   prog_instr = '0;
    logic [19:0]   prog_oreg = '0;
    logic [CW-1:0] prog_len = '0;
    logic          start = 1'b0;
    logic          in_valid;
    logic [31:0]   instruction;
    logic [19:0]   output_reg;
    logic          out_valid = 1'b0;
    logic          instruction_fail = 1'b0;
    logic [31:0]   out_1 = '0, out_2 = '0, out_3 = '0, out_4 = '0;
    logic          busy, done, timeout;
    logic [CW-1:0] fail_cnt;
    logic [31:0]   res_sum;

    always #5 clk = ~clk;

    mips_issuer #(.DEPTH(DEPTH), .WDT_CYCLES(WDT)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_instr(prog_instr), .prog_oreg(prog_oreg), .prog_len(prog_len), .start(start),
        .in_valid(in_valid), .instruction(instruction), .output_reg(output_reg),
        .out_valid(out_valid), .instruction_fail(instruction_fail),
        .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4),
        .busy(busy), .done(done), .timeout(timeout), .fail_cnt(fail_cnt), .res_sum(res_sum)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct packed {
        logic        fail;
        logic [31:0] w1, w2, w3, w4;
    } resp_t;
    resp_t resp_q[$];
    int    pend_due[$];
    int    lat = 2;
    int    ret_limit = 1000000;
    int    n_ret = 0;

    // Reference model: what a run must look like, tracked as counts and sums.
    logic [31:0] m_instr [DEPTH];
    logic [19:0] m_oreg  [DEPTH];
    bit          m_active, m_done, m_tmo;
    int          m_len, m_issued, m_rcv, m_idle, m_fail;
    logic [31:0] m_sum;

    int          iv_cnt = 0, iv_rises = 0, done_cnt = 0, tmo_cnt = 0;
    int          done_cyc = 0, tmo_cyc = 0, last_ov_cyc = 0;
    logic [31:0] last_instr = '0;
    bit          prev_iv = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
        m_len = 0; m_issued = 0; m_rcv = 0; m_idle = 0; m_fail = 0; m_sum = '0;
    endtask

    task automatic model_advance();
        bit draining;
        m_done = 1'b0;
        m_tmo  = 1'b0;
        if (!m_active) begin
            if (prog_we) begin
                m_instr[prog_addr] = prog_instr;
                m_oreg[prog_addr]  = prog_oreg;
            end
            if (start && prog_len != 0) begin
                m_active = 1'b1;
                m_len    = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
                m_issued = 0; m_rcv = 0; m_idle = 0; m_fail = 0; m_sum = '0;
            end
        end else begin
            draining = (m_issued == m_len);
            if (!draining) m_issued++;
            if (out_valid) begin
                m_rcv++;
                m_idle = 0;
                if (instruction_fail) m_fail++;
                else m_sum = m_sum + out_1 + out_2 + out_3 + out_4;
                if (m_rcv == m_len) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (WDT_EN && draining) begin
                m_idle++;
                if (m_idle + 1 >= WDT) begin
                    m_active = 1'b0;
                    m_tmo    = 1'b1;
                end
            end
        end
    endtask

    // Compare process: every cycle, on the falling edge.
    initial begin
        bit          exp_iv;
        logic [31:0] exp_i;
        logic [19:0] exp_o;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            exp_iv = m_active && (m_issued < m_len);
            exp_i  = '0;
            exp_o  = '0;
            if (exp_iv) begin
                exp_i = m_instr[m_issued];
                exp_o = m_oreg[m_issued];
            end
            check("in_valid",    64'(in_valid),    64'(exp_iv));
            check("instruction", 64'(instruction), 64'(exp_i));
            check("output_reg",  64'(output_reg),  64'(exp_o));
            check("busy",        64'(busy),        64'(m_active));
            check("done",        64'(done),        64'(m_done));
            check("timeout",     64'(timeout),     64'(m_tmo));
            check("fail_cnt",    64'(fail_cnt),    64'(m_fail));
            check("res_sum",     64'(res_sum),     64'(m_sum));
            if (in_valid) begin
                iv_cnt++;
                last_instr = instruction;
                if (!prev_iv) iv_rises++;
            end
            prev_iv = in_valid;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (timeout) begin tmo_cnt++; tmo_cyc = cyc; end
            if (out_valid && busy) last_ov_cyc = cyc;
            if (rst_n) model_advance();
        end
    end

    task automatic step();
        resp_t r;
        int    due;
        if (in_valid) pend_due.push_back(cyc + lat);
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0; prog_we = 1'b0;
        out_valid = 1'b0; instruction_fail = 1'b0;
        out_1 = '0; out_2 = '0; out_3 = '0; out_4 = '0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            due = pend_due.pop_front();
            if (n_ret < ret_limit) begin
                n_ret++;
                if (resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                end else begin
                    r.fail = ($urandom_range(0, 3) == 0);
                    r.w1 = $urandom; r.w2 = $urandom; r.w3 = $urandom; r.w4 = $urandom;
                end
                out_valid = 1'b1; instruction_fail = r.fail;
                out_1 = r.w1; out_2 = r.w2; out_3 = r.w3; out_4 = r.w4;
            end
        end
    endtask

    task automatic load(input int a, input logic [31:0] i, input logic [19:0] o);
        prog_we = 1'b1; prog_addr = AW'(a); prog_instr = i; prog_oreg = o;
        step();
    endtask

    task automatic kick(input int len);
        pend_due.delete();
        n_ret = 0;
        prog_len = CW'(len);
        start = 1'b1;
        step();
    endtask

    task automatic wait_idle(input int budget, input bit inject);
        int k = 0;
        while (busy && k < budget) begin
            if (inject && $urandom_range(0, 7) == 0) begin
                start = 1'b1; prog_len = CW'($urandom_range(1, DEPTH));
                prog_we = 1'b1; prog_addr = AW'($urandom_range(0, DEPTH - 1));
                prog_instr = $urandom; prog_oreg = 20'($urandom);
            end
            step();
            k++;
        end
        if (busy) begin
            n_chk++; n_fail++;
            $display("FAIL run_bound: busy still 1 after %0d cycles, required 0", budget);
        end
        step();
    endtask

    function automatic resp_t mk(input logic f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d);
        resp_t r;
        r.fail = f; r.w1 = a; r.w2 = b; r.w3 = c; r.w4 = d;
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int          b_iv, b_rise, b_done, b_tmo;
        logic [31:0] e0;
        rst_n = 1'b0;
        step(); step();
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_in_valid", 64'(in_valid), 64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_timeout",  64'(timeout),  64'd0);
        check("rst_fail_cnt", 64'(fail_cnt), 64'd0);
        check("rst_res_sum",  64'(res_sum),  64'd0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) load(i, $urandom, 20'($urandom));

        // Single ADDI issue returning 1+2+3+4.
        load(0, 32'h22310005, 20'h00000);
        lat = 2;
        resp_q.push_back(mk(1'b0, 32'd1, 32'd2, 32'd3, 32'd4));
        b_iv = iv_cnt; b_done = done_cnt;
        kick(1); wait_idle(50, 1'b0);
        check("t1_iv_count",   64'(iv_cnt - b_iv),     64'd1);
        check("t1_done_count", 64'(done_cnt - b_done), 64'd1);
        check("t1_instr",      64'(last_instr),        64'h22310005);
        check("t1_res_sum",    64'(res_sum),           64'd10);
        check("t1_fail_cnt",   64'(fail_cnt),          64'd0);

        // Full program, 4-cycle latency responder.
        for (int i = 0; i < DEPTH; i++) load(i, $urandom, 20'($urandom));
        lat = 4;
        b_iv = iv_cnt; b_rise = iv_rises; b_done = done_cnt;
        kick(16); wait_idle(100, 1'b0);
        check("t2_iv_count",   64'(iv_cnt - b_iv),         64'd16);
        check("t2_iv_bursts",  64'(iv_rises - b_rise),     64'd1);
        check("t2_done_count", 64'(done_cnt - b_done),     64'd1);
        check("t2_done_delay", 64'(done_cyc - last_ov_cyc), 64'd1);

        // Mixed failures.
        lat = 1;
        resp_q.push_back(mk(1'b1, 32'd5, 32'd5, 32'd5, 32'd5));
        resp_q.push_back(mk(1'b0, 32'd5, 32'd5, 32'd5, 32'd5));
        resp_q.push_back(mk(1'b1, 32'd5, 32'd5, 32'd5, 32'd5));
        kick(3); wait_idle(50, 1'b0);
        check("t3_fail_cnt", 64'(fail_cnt), 64'd2);
        check("t3_res_sum",  64'(res_sum),  64'd20);

        // Checksum wrap, with start and prog_we attempted mid-run.
        e0 = m_instr[0];
        lat = 3;
        resp_q.push_back(mk(1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0));
        resp_q.push_back(mk(1'b0, 32'd0, 32'd0, 32'd0, 32'd0));
        b_iv = iv_cnt;
        kick(2);
        start = 1'b1; prog_len = CW'(5);
        prog_we = 1'b1; prog_addr = '0; prog_instr = 32'hDEADBEEF; prog_oreg = 20'hABCDE;
        step();
        wait_idle(50, 1'b0);
        check("t4_res_sum",  64'(res_sum),       64'd0);
        check("t4_iv_count", 64'(iv_cnt - b_iv), 64'd2);
        kick(1); wait_idle(50, 1'b0);
        check("t4_entry0_kept", 64'(last_instr), 64'(e0));

        // Both results land during ISSUE, the second with the last issue.
        ret_limit = 0;
        b_done = done_cnt; b_iv = iv_cnt;
        kick(2);
        out_valid = 1'b1; out_1 = 32'd1; out_2 = 32'd2; out_3 = 32'd3; out_4 = 32'd4;
        step();
        out_valid = 1'b1; out_1 = 32'd10; out_2 = 32'd20; out_3 = 32'd30; out_4 = 32'd40;
        step();
        step();
        check("t7_done_count", 64'(done_cnt - b_done), 64'd1);
        check("t7_iv_count",   64'(iv_cnt - b_iv),     64'd2);
        check("t7_res_sum",    64'(res_sum),           64'd110);
        check("t7_busy",       64'(busy),              64'd0);

        // Dropped second result.
        lat = 2;
        b_done = done_cnt; b_tmo = tmo_cnt;
        kick(2);
        ret_limit = 1;
        if (WDT_EN) begin
            wait_idle(100, 1'b0);
            check("t5_tmo_count",  64'(tmo_cnt - b_tmo),        64'd1);
            check("t5_done_count", 64'(done_cnt - b_done),      64'd0);
            check("t5_tmo_delay",  64'(tmo_cyc - last_ov_cyc),  64'd8);
        end else begin
            repeat (40) step();
            check("t5_busy_hold",  64'(busy),                   64'd1);
            check("t5_done_count", 64'(done_cnt - b_done),      64'd0);
            rst_n = 1'b0; step(); rst_n = 1'b1; step();
        end
        ret_limit = 1000000;

        // Reset in the middle of ISSUE, then stray results while idle.
        lat = 3;
        b_done = done_cnt;
        kick(8); step(); step();
        rst_n = 1'b0;
        pend_due.delete();
        #1;
        check("t6_in_valid", 64'(in_valid),    64'd0);
        check("t6_instr",    64'(instruction), 64'd0);
        check("t6_oreg",     64'(output_reg),  64'd0);
        check("t6_busy",     64'(busy),        64'd0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_valid = 1'b1; instruction_fail = i[0];
            out_1 = 32'd7; out_2 = 32'd7; out_3 = 32'd7; out_4 = 32'd7;
            step();
        end
        step();
        check("t6_fail_cnt",   64'(fail_cnt),          64'd0);
        check("t6_res_sum",    64'(res_sum),           64'd0);
        check("t6_done_count", 64'(done_cnt - b_done), 64'd0);

        // Randomized runs, including zero and oversize lengths and ignored mid-run requests.
        for (int r = 0; r < 30; r++) begin
            for (int j = 0; j < 4; j++) load($urandom_range(0, DEPTH - 1), $urandom, 20'($urandom));
            lat = $urandom_range(1, 5);
            kick($urandom_range(0, DEPTH + 3));
            wait_idle(300, 1'b1);
            check("rand_idle", 64'(busy), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
